// File: rtl/sync_mod_updown_counter_if.sv
// Control/status bundle for sync_mod_updown_counter.
// The master drives the count controls; the counter (slave) returns count and status.
interface sync_mod_updown_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   logic             ld_err;
   logic             done;

   modport master (
      output en, up_dn, load, load_val,
      input  q, tc, wrap, ld_err, done
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output q, tc, wrap, ld_err, done
   );
endinterface

// File: rtl/sync_mod_updown_counter.sv
// Parametrised synchronous modulo-MOD up/down counter with load, terminal count,
// wrap/load-error pulses and an optional one-shot (stop at bound) mode.
module sync_mod_updown_counter #(
   parameter int unsigned      WIDTH   = 4,
   parameter longint unsigned  MOD     = 10,
   parameter int unsigned      ONESHOT = 0
) (
   input logic                    clk,
   input logic                    rst_n,
   sync_mod_updown_counter_if.slave bus
);
   localparam int unsigned     CW       = WIDTH + 1;
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MOD - 64'd1);
   localparam logic [CW-1:0]   MOD_EXT  = CW'(MOD);
   localparam logic [CW-1:0]   MAX_EXT  = CW'(MOD - 64'd1);
   localparam bit              ONE_SHOT = (ONESHOT != 0);

   if (WIDTH < 1 || WIDTH > 32 || MOD < 64'd2 || MOD > (64'd1 << WIDTH)) begin : g_bad_param
      $error("sync_mod_updown_counter: illegal WIDTH/MOD combination");
   end

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic             wrap_r, wrap_nxt;
   logic             ld_err_r, ld_err_nxt;

   logic [CW-1:0]    q_ext;
   logic [CW-1:0]    lv_ext;
   logic             at_bound_c;
   logic             done_c;
   logic             tc_c;

   // Bound detection and terminal count, all at WIDTH+1 bits
   always_comb begin
      q_ext      = {1'b0, q_r};
      lv_ext     = {1'b0, bus.load_val};
      at_bound_c = bus.up_dn ? (q_ext == MAX_EXT) : (q_ext == '0);
      done_c     = ONE_SHOT && (state == ST_DONE);
      tc_c       = bus.en && !bus.load && at_bound_c && !done_c;
   end

   // State/count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         q_r      <= '0;
         wrap_r   <= 1'b0;
         ld_err_r <= 1'b0;
      end else begin
         state    <= state_nxt;
         q_r      <= q_nxt;
         wrap_r   <= wrap_nxt;
         ld_err_r <= ld_err_nxt;
      end
   end

   // Next-state: load > terminal count > ordinary count > hold
   always_comb begin
      state_nxt  = state;
      q_nxt      = q_r;
      wrap_nxt   = 1'b0;
      ld_err_nxt = 1'b0;

      if (bus.load) begin
         state_nxt = ST_RUN;
         if (lv_ext < MOD_EXT) begin
            q_nxt = bus.load_val;
         end else begin
            q_nxt      = MAX_Q;
            ld_err_nxt = 1'b1;
         end
      end else if (tc_c) begin
         if (ONE_SHOT) begin
            state_nxt = ST_DONE;
         end else begin
            q_nxt    = bus.up_dn ? '0 : MAX_Q;
            wrap_nxt = 1'b1;
         end
      end else if (bus.en && !done_c) begin
         q_nxt = bus.up_dn ? WIDTH'(q_ext + CW'(1)) : WIDTH'(q_ext - CW'(1));
      end
   end

   assign bus.q      = q_r;
   assign bus.tc     = tc_c;
   assign bus.wrap   = wrap_r;
   assign bus.ld_err = ld_err_r;
   assign bus.done   = done_c;
endmodule
